// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per CLKS_PER_BIT cycles, with so_valid framing and a done pulse.
module piso_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_nxt;
  logic [DW-1:0]    r_div_cnt;
  logic [DW-1:0]    w_div_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_rdy_en;
  logic             w_out_bit;

  // Next-state, datapath and done-pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit_cnt;
    w_div_nxt   = r_div_cnt;
    w_done_nxt  = 1'b0;
    if (MSB_FIRST != 0) begin
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      w_out_bit = r_shreg[WIDTH-1];
    end else begin
      w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      w_out_bit = r_shreg[0];
    end
    case (r_state)
      IDLE: begin
        // r_rdy_en keeps the first post-reset cycle from accepting a word
        if (din_valid && r_rdy_en) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = din;
          w_bit_nxt   = {BW{1'b0}};
          w_div_nxt   = {DW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt   = {DW{1'b0}};
          w_shreg_nxt = w_shifted;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = {BW{1'b0}};
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end else begin
          w_div_nxt = r_div_cnt + DW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= {WIDTH{1'b0}};
      r_bit_cnt <= {BW{1'b0}};
      r_div_cnt <= {DW{1'b0}};
      r_done    <= 1'b0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_div_cnt <= w_div_nxt;
      r_done    <= w_done_nxt;
      r_rdy_en  <= 1'b1;
    end
  end

  assign busy      = (r_state == SHIFT);
  assign so_valid  = busy;
  assign din_ready = r_rdy_en & ~busy;
  assign so        = busy & w_out_bit;
  assign done      = r_done;

endmodule
